// File: rtl/scan_mux_pkg.sv
// Shared types and defaults for the scan_mux display multiplexer.
package scan_mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } scan_mode_e;

    localparam int unsigned DEFAULT_SCAN_DIV     = 1000;
    localparam int unsigned DEFAULT_BLANK_CYCLES = 2;

    // Index width never collapses to zero, even for a two-channel mux.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_mux_prescaler.sv
// Free-running divider: counts 0..DIV-1 while enabled and flags the last count.
module scan_prescaler #(
    parameter int unsigned DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel data selector with strobe and auto-scan for digit multiplexing.
// Define SCAN_MUX_BLANK_EN to add dead-time on dig_en after each auto-scan step.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int unsigned CHANNELS     = 8,
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned SCAN_DIV     = DEFAULT_SCAN_DIV,
    parameter int unsigned BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
    localparam int unsigned IW          = idx_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_n,
    input  logic                      mode,
    input  logic [IW-1:0]             sel,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [WIDTH-1:0]          q,
    output logic [WIDTH-1:0]          q_n,
    output logic [IW-1:0]             idx,
    output logic [CHANNELS-1:0]       dig_en,
    output logic                      scan_wrap
);

    localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);

    if (CHANNELS < 2 || SCAN_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV)
    begin : g_bad_params
        $error("scan_mux: illegal parameter combination");
    end

    scan_mode_e          mode_e;
    logic                scanning;
    logic                tick;
    logic                blank;
    logic [IW-1:0]       scan_idx_q;
    logic [IW-1:0]       eff;
    logic [CHANNELS-1:0] one_hot;
    logic [WIDTH-1:0]    sel_data;

    assign mode_e   = scan_mode_e'(mode);
    assign scanning = (mode_e == MODE_SCAN);

    // Prescaler parks at 0 in manual mode so the first tick lands SCAN_DIV cycles after entry.
    scan_prescaler #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (scanning && !s_n),
        .clr  (!scanning),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx_q <= '0;
        end else if (!s_n) begin
            if (!scanning) begin
                scan_idx_q <= sel;
            end else if (tick) begin
                scan_idx_q <= (scan_idx_q >= LAST_IDX) ? '0 : scan_idx_q + 1'b1;
            end
        end
    end

    // Out-of-range indices leave both one_hot and sel_data at zero.
    always_comb begin
        eff      = scanning ? scan_idx_q : sel;
        one_hot  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (eff == IW'(i)) begin
                one_hot[i] = 1'b1;
                sel_data   = d[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef SCAN_MUX_BLANK_EN
    localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);

    logic [BW-1:0] blank_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !scanning) begin
            blank_cnt_q <= '0;
        end else if (!s_n) begin
            if (tick) begin
                blank_cnt_q <= BW'(BLANK_CYCLES);
            end else if (blank_cnt_q != '0) begin
                blank_cnt_q <= blank_cnt_q - 1'b1;
            end
        end
    end

    assign blank = scanning && (blank_cnt_q != '0);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            q_n       <= '1;
            idx       <= '0;
            dig_en    <= '0;
            scan_wrap <= 1'b0;
        end else if (s_n) begin
            q         <= '0;
            q_n       <= '1;
            dig_en    <= '0;
            scan_wrap <= 1'b0;
        end else begin
            q         <= sel_data;
            q_n       <= ~sel_data;
            idx       <= eff;
            dig_en    <= blank ? '0 : one_hot;
            scan_wrap <= scanning && tick && (scan_idx_q >= LAST_IDX);
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: driver queues expectations, monitor checks each cycle.
module tb_scan_mux;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 2;
    localparam logic [31:0] D1    = 32'h7654_3210;
    localparam logic [31:0] D2    = 32'h9E3C_5A71;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_n = 1'b0;
    logic        mode = 1'b1;
    logic [2:0]  sel = '0;
    logic [31:0] d = '0;
    logic [3:0]  q;
    logic [3:0]  q_n;
    logic [2:0]  idx;
    logic [7:0]  dig_en;
    logic        scan_wrap;

    typedef struct {
        logic [3:0] q;
        logic [2:0] idx;
        logic [7:0] dig;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    scan_mux #(
        .CHANNELS     (8),
        .WIDTH        (4),
        .SCAN_DIV     (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_n       (s_n),
        .mode      (mode),
        .sel       (sel),
        .d         (d),
        .q         (q),
        .q_n       (q_n),
        .idx       (idx),
        .dig_en    (dig_en),
        .scan_wrap (scan_wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ch(input logic [31:0] dd, input int i);
        return dd[i*4 +: 4];
    endfunction

    function automatic logic [7:0] oh(input int i);
        logic [7:0] v;
        v = 8'h01;
        return v << i;
    endfunction

    // k counts auto-mode edges since scanning began with the prescaler at 0.
    function automatic bit blanked(input int k);
`ifdef SCAN_MUX_BLANK_EN
        return (k > DIV) && (((k - 1) % DIV) < BLANK);
`else
        return (k < 0);
`endif
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic sn, input logic m, input logic [2:0] s,
                        input logic [31:0] dd, input logic [3:0] eq, input logic [2:0] ei,
                        input logic [7:0] ed, input logic ew);
        @(negedge clk);
        rst  = r;
        s_n  = sn;
        mode = m;
        sel  = s;
        d    = dd;
        exp_q.push_back('{eq, ei, ed, ew});
    endtask

    task automatic auto_run(input int k0, input int k1, input int base);
        int i;
        for (int k = k0; k <= k1; k++) begin
            i = (base + (k - 1) / DIV) % 8;
            step(0, 0, 1, 3'd0, D2, ch(D2, i), 3'(i), blanked(k) ? 8'h00 : oh(i),
                 (base == 0) && (k == 32));
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("q", {4'h0, q}, {4'h0, e.q});
            check("q_n", {4'h0, q_n}, {4'h0, ~e.q});
            check("idx", {5'h0, idx}, {5'h0, e.idx});
            check("dig_en", dig_en, e.dig);
            check("scan_wrap", {7'h0, scan_wrap}, {7'h0, e.wrap});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two cycles while strobed and in auto mode.
        step(1, 0, 1, 3'd0, D2, 4'h0, 3'd0, 8'h00, 1'b0);
        step(1, 0, 1, 3'd0, D2, 4'h0, 3'd0, 8'h00, 1'b0);

        // Manual selection, including both ends of the index range.
        step(0, 0, 0, 3'd5, D1, 4'h5, 3'd5, 8'h20, 1'b0);
        step(0, 0, 0, 3'd2, D1, 4'h2, 3'd2, 8'h04, 1'b0);
        step(0, 0, 0, 3'd7, D2, 4'h9, 3'd7, 8'h80, 1'b0);
        step(0, 0, 0, 3'd0, D2, 4'h1, 3'd0, 8'h01, 1'b0);
        step(0, 0, 0, 3'd5, D1, 4'h5, 3'd5, 8'h20, 1'b0);

        // Strobe high blanks outputs but idx holds.
        step(0, 1, 0, 3'd5, D1, 4'h0, 3'd5, 8'h00, 1'b0);
        step(0, 1, 0, 3'd1, D1, 4'h0, 3'd5, 8'h00, 1'b0);
        step(0, 0, 0, 3'd5, D1, 4'h5, 3'd5, 8'h20, 1'b0);

        // Park on channel 0, then scan a full frame plus one channel.
        step(0, 0, 0, 3'd0, D2, 4'h1, 3'd0, 8'h01, 1'b0);
        auto_run(1, 36, 0);

        // Freeze at channel 3 halfway through its prescaler count.
        step(0, 0, 0, 3'd3, D2, 4'h5, 3'd3, 8'h08, 1'b0);
        auto_run(1, 2, 3);
        for (int n = 0; n < 10; n++) begin
            step(0, 1, 1, 3'd0, D2, 4'h0, 3'd3, 8'h00, 1'b0);
        end
        auto_run(3, 12, 3);

        // Back to manual: sel takes effect on the next edge.
        step(0, 0, 0, 3'd6, D2, 4'hE, 3'd6, 8'h40, 1'b0);

        // Reset mid-scan with strobe high, then scan restarts from channel 0.
        auto_run(1, 3, 6);
        step(1, 1, 1, 3'd4, D2, 4'h0, 3'd0, 8'h00, 1'b0);
        step(1, 1, 1, 3'd4, D2, 4'h0, 3'd0, 8'h00, 1'b0);
        auto_run(1, 6, 0);

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parameterised, registered N-channel, W-bit multiplexer with an active-low strobe, in the style of the 74LS151. It adds an auto-scan mode that steps through the channels on a programmable prescaler tick and drives a one-hot channel-enable bus. It sits between the digital clock's BCD counters and the seven-segment decoder, and time-multiplexes digits onto a shared segment bus. In manual mode it acts as a wide clocked 151-class data selector.

## Interface
- CHANNELS, 8, number of input channels (≥2)
- WIDTH, 4, bits per channel
- SCAN_DIV, 1000, clk cycles per channel in auto mode (≥2)
- BLANK_CYCLES, 2, dead-time cycles per channel switch (1 ≤ BLANK_CYCLES < SCAN_DIV); used only with SCAN_MUX_BLANK_EN
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- s_n  in  1  strobe, active low; high forces the outputs inactive and freezes the scan
- mode  in  1  0 = manual select, 1 = auto-scan
- sel  in  IW = max(1,$clog2(CHANNELS))  channel index in manual mode
- d  in  CHANNELS*WIDTH  flattened data; channel i = d[i*WIDTH +: WIDTH]
- q  out  WIDTH  selected data, registered
- q_n  out  WIDTH  bitwise ~q, registered
- idx  out  IW  channel index currently presented on q
- dig_en  out  CHANNELS  one-hot enable for the channel on q, registered
- scan_wrap  out  1  one-cycle pulse when the auto index wraps from CHANNELS-1 to 0

## Operation
- Effective index: eff = mode ? scan_idx : sel.
- Each cycle with s_n=0:
  - q <= d[eff]; q_n <= ~d[eff]; idx <= eff; dig_en <= 1<<eff.
  - If eff ≥ CHANNELS (non-power-of-two CHANNELS), then q=0, q_n=all-ones, dig_en=0.
- s_n=1: q=0, q_n=all-ones, dig_en=0, scan_wrap=0. The prescaler and scan_idx hold their values; idx holds.
- Auto mode:
  - The prescaler counts 0..SCAN_DIV-1 and asserts tick on SCAN_DIV-1, then returns to 0.
  - On tick, scan_idx goes to scan_idx+1, or to 0 when scan_idx = CHANNELS-1. scan_wrap pulses on the same edge as that wrap.
- Manual mode: the prescaler is held at 0 and scan_idx <= sel each cycle, so that auto-scan resumes from the last manual channel.
- Mode change 0→1: the first tick arrives SCAN_DIV cycles after the change. Mode change 1→0: sel takes effect on the next edge.
- Reset mid-scan: all state returns to reset values on the next edge, regardless of s_n and mode.

## Timing
- Reset values: q=0, q_n=all-ones, idx=0, dig_en=0, scan_wrap=0, scan_idx=0, prescaler=0.
- Latency from d, sel, s_n or mode to q, q_n, idx and dig_en is 1 cycle.
- In auto mode, a channel is presented for exactly SCAN_DIV cycles. A full frame is CHANNELS*SCAN_DIV cycles.
- scan_wrap is registered and coincides with the first cycle in which the internal scan_idx = 0. q shows channel 0 one cycle later.

## Configuration
- SCAN_MUX_BLANK_EN defined:
  - In auto mode, after every scan_idx change, dig_en is forced to 0 for BLANK_CYCLES cycles, then shows the new one-hot value.
  - q and idx update with no extra delay.
  - Manual mode is not affected.
- SCAN_MUX_BLANK_EN undefined: dig_en switches directly, BLANK_CYCLES is ignored, and no blanking counter is synthesised.

## Structure
- Package scan_mux_pkg holds:
  - the function idx_width(n) = max(1,$clog2(n));
  - the typedef for the mode encoding (MODE_MANUAL=0, MODE_SCAN=1);
  - the default constants for SCAN_DIV and BLANK_CYCLES.
- Sub-module scan_prescaler:
  - parameter DIV;
  - inputs clk, rst, en, clr;
  - output tick;
  - counter width $clog2(DIV).
- The top level holds scan_idx, the selection logic, the output registers and the optional blanking counter.

## Test plan
- Reset: assert rst for 2 cycles with s_n=0 and mode=1 → q=0, q_n=4'hF, dig_en=0, idx=0 on the first edge after rst and for as long as rst is held.
- Manual select: CHANNELS=8, d={8'h76,8'h54,8'h32,8'h10} (channel i = i), mode=0, sel=5 → q=4'h5, q_n=4'hA, dig_en=8'h20 one cycle later.
- Strobe: from the previous state, raise s_n → next cycle q=0, dig_en=0. Lower s_n → q=4'h5 one cycle later.
- Auto scan: SCAN_DIV=4, mode=1 → idx advances every 4 cycles through 0..7. scan_wrap pulses exactly once per 32 cycles, when the internal index wraps 7→0.
- Freeze: auto mode at scan_idx=3, hold s_n=1 for 10 cycles → on release, scan resumes at index 3 with the remaining prescaler count unchanged.
- Blanking (SCAN_MUX_BLANK_EN, BLANK_CYCLES=2, SCAN_DIV=8) → dig_en=0 for 2 cycles after each index change and then one-hot. q shows the new channel with no delay.
